qdrc_req_arb: RTL and testbench

//  Request arbiter and read-tag tracker directly upstream of the QDR controller top level.

---
 rtl/qdrc_pkg.sv | 14 +
 rtl/qdrc_tag_fifo.sv | 57 +++++
 rtl/qdrc_req_arb.sv | 137 +++++++++++++
 tb/tb_qdrc_req_arb.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qdrc_pkg.sv
// Shared types and constants for the QDR request arbiter and its tag FIFO.
package qdrc_pkg;

  typedef logic [0:0] arb_state_t;
  localparam logic [0:0] WAIT_RDY = 1'b0;
  localparam logic [0:0] RUN      = 1'b1;

  localparam int QDRC_LATENCY = 11;

  function automatic int user_width(input int data_width);
    return 2 * data_width;
  endfunction

endpackage

// File: rtl/qdrc_tag_fifo.sv
// First-word-fall-through FIFO holding the tags of reads issued to the controller.
// The head entry is visible on pop_data whenever the FIFO is not empty.
module qdrc_tag_fifo
  import qdrc_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == (PW+1)'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr_reg];
  assign count    = count_reg;

  // Storage is left unreset; only pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/qdrc_req_arb.sv
// Write/read request arbiter and read-tag tracker in front of the QDR controller.
// Optional transfer/stall statistics are built when QDRC_REQ_ARB_STATS_EN is defined.
module qdrc_req_arb
  import qdrc_pkg::*;
#(
  parameter int DATA_WIDTH     = 36,
  parameter int ADDR_WIDTH     = 21,
  parameter int TAG_WIDTH      = 4,
  parameter int OUTSTANDING    = 16,
  parameter int WR_BURST_LIMIT = 4
) (
  input  logic                               clk0,
  input  logic                               reset,
  input  logic                               phy_rdy,
  input  logic                               wr_req_valid,
  output logic                               wr_req_ready,
  input  logic [ADDR_WIDTH-1:0]              wr_req_addr,
  input  logic [user_width(DATA_WIDTH)-1:0]  wr_req_data,
  input  logic                               rd_req_valid,
  output logic                               rd_req_ready,
  input  logic [ADDR_WIDTH-1:0]              rd_req_addr,
  input  logic [TAG_WIDTH-1:0]               rd_req_tag,
  output logic                               usr_wr_strb,
  output logic                               usr_rd_strb,
  output logic [ADDR_WIDTH-1:0]              usr_addr,
  output logic [user_width(DATA_WIDTH)-1:0]  usr_wr_data,
  input  logic [user_width(DATA_WIDTH)-1:0]  usr_rd_data,
  input  logic                               usr_rd_dvld,
  output logic                               rd_rsp_valid,
  output logic [user_width(DATA_WIDTH)-1:0]  rd_rsp_data,
  output logic [TAG_WIDTH-1:0]               rd_rsp_tag,
  output logic [$clog2(OUTSTANDING):0]       rd_inflight,
  output logic                               rsp_underflow
`ifdef QDRC_REQ_ARB_STATS_EN
  ,
  output logic [31:0]                        stat_wr_cnt,
  output logic [31:0]                        stat_rd_cnt,
  output logic [31:0]                        stat_stall_cnt
`endif
);

  localparam int SW = $clog2(WR_BURST_LIMIT + 1);

  arb_state_t           state_reg;
  logic [SW-1:0]        streak_reg;
  logic [SW-1:0]        streak_next;
  logic                 run;
  logic                 rd_eligible;
  logic                 at_limit;
  logic                 grant_wr;
  logic                 grant_rd;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [TAG_WIDTH-1:0] head_tag;
  logic                 rsp_pop;

  // A full FIFO means OUTSTANDING reads are in flight; this uses the registered count.
  assign run         = (state_reg == RUN);
  assign rd_eligible = rd_req_valid && !fifo_full;
  assign at_limit    = (streak_reg == SW'(WR_BURST_LIMIT));
  assign grant_rd    = run && rd_eligible && (!wr_req_valid || at_limit);
  assign grant_wr    = run && wr_req_valid && !grant_rd;

  assign wr_req_ready = grant_wr;
  assign rd_req_ready = grant_rd;
  assign rsp_pop      = usr_rd_dvld && !fifo_empty;

  always_comb begin
    streak_next = streak_reg;
    if (!rd_req_valid || grant_rd)
      streak_next = '0;
    else if (grant_wr && !at_limit)
      streak_next = streak_reg + 1'b1;
  end

  qdrc_tag_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (TAG_WIDTH)
  ) u_tag_fifo (
    .clk       (clk0),
    .reset     (reset),
    .push      (grant_rd),
    .push_data (rd_req_tag),
    .pop       (usr_rd_dvld),
    .pop_data  (head_tag),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (rd_inflight)
  );

  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      state_reg     <= WAIT_RDY;
      streak_reg    <= '0;
      usr_wr_strb   <= 1'b0;
      usr_rd_strb   <= 1'b0;
      usr_addr      <= '0;
      usr_wr_data   <= '0;
      rd_rsp_valid  <= 1'b0;
      rd_rsp_data   <= '0;
      rd_rsp_tag    <= '0;
      rsp_underflow <= 1'b0;
    end else begin
      state_reg   <= phy_rdy ? RUN : WAIT_RDY;
      streak_reg  <= streak_next;
      usr_wr_strb <= grant_wr;
      usr_rd_strb <= grant_rd;
      if (grant_wr) begin
        usr_addr    <= wr_req_addr;
        usr_wr_data <= wr_req_data;
      end else if (grant_rd) begin
        usr_addr <= rd_req_addr;
      end
      rd_rsp_valid <= rsp_pop;
      if (rsp_pop) begin
        rd_rsp_data <= usr_rd_data;
        rd_rsp_tag  <= head_tag;
      end
      if (usr_rd_dvld && fifo_empty) rsp_underflow <= 1'b1;
    end
  end

`ifdef QDRC_REQ_ARB_STATS_EN
  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      stat_wr_cnt    <= '0;
      stat_rd_cnt    <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (grant_wr) stat_wr_cnt <= stat_wr_cnt + 32'd1;
      if (grant_rd) stat_rd_cnt <= stat_rd_cnt + 32'd1;
      if (run && rd_req_valid && !grant_rd) stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_qdrc_req_arb.sv
// Scoreboard bench for qdrc_req_arb: expected commands and responses are queued
// when stimulus is applied and compared when the DUT presents them.
`timescale 1ns/1ps
module tb_qdrc_req_arb;

  localparam int DW  = 36;
  localparam int AW  = 21;
  localparam int TW  = 4;
  localparam int OUT = 16;
  localparam int LIM = 4;
  localparam int UW  = 2 * DW;

  logic          clk0 = 1'b0;
  logic          reset;
  logic          phy_rdy;
  logic          wr_req_valid;
  logic          wr_req_ready;
  logic [AW-1:0] wr_req_addr;
  logic [UW-1:0] wr_req_data;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic [TW-1:0] rd_req_tag;
  logic          usr_wr_strb;
  logic          usr_rd_strb;
  logic [AW-1:0] usr_addr;
  logic [UW-1:0] usr_wr_data;
  logic [UW-1:0] usr_rd_data;
  logic          usr_rd_dvld;
  logic          rd_rsp_valid;
  logic [UW-1:0] rd_rsp_data;
  logic [TW-1:0] rd_rsp_tag;
  logic [4:0]    rd_inflight;
  logic          rsp_underflow;
`ifdef QDRC_REQ_ARB_STATS_EN
  logic [31:0]   stat_wr_cnt;
  logic [31:0]   stat_rd_cnt;
  logic [31:0]   stat_stall_cnt;
`endif

  qdrc_req_arb #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .TAG_WIDTH (TW),
    .OUTSTANDING (OUT), .WR_BURST_LIMIT (LIM)
  ) dut (
    .clk0 (clk0), .reset (reset), .phy_rdy (phy_rdy),
    .wr_req_valid (wr_req_valid), .wr_req_ready (wr_req_ready),
    .wr_req_addr (wr_req_addr), .wr_req_data (wr_req_data),
    .rd_req_valid (rd_req_valid), .rd_req_ready (rd_req_ready),
    .rd_req_addr (rd_req_addr), .rd_req_tag (rd_req_tag),
    .usr_wr_strb (usr_wr_strb), .usr_rd_strb (usr_rd_strb),
    .usr_addr (usr_addr), .usr_wr_data (usr_wr_data),
    .usr_rd_data (usr_rd_data), .usr_rd_dvld (usr_rd_dvld),
    .rd_rsp_valid (rd_rsp_valid), .rd_rsp_data (rd_rsp_data),
    .rd_rsp_tag (rd_rsp_tag), .rd_inflight (rd_inflight),
    .rsp_underflow (rsp_underflow)
`ifdef QDRC_REQ_ARB_STATS_EN
    , .stat_wr_cnt (stat_wr_cnt), .stat_rd_cnt (stat_rd_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  always #5 clk0 = ~clk0;

  typedef struct {
    int            due;
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [UW-1:0] data;
  } cmd_t;

  typedef struct {
    int            due;
    logic [UW-1:0] data;
    logic [TW-1:0] tag;
  } rsp_t;

  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  cmd_t          cmd_q[$];
  rsp_t          rsp_q[$];
  logic [TW-1:0] m_tags[$];
  logic [TW-1:0] seen_tags[$];
  int            ret_q[$];
  logic          m_run;
  int            m_streak;
  logic          m_uflow;
  logic          auto_ret;
  logic          man_dvld;
  logic          last_gr;
  logic          last_gw;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock of stimulus: outputs from the last edge are scored at the falling
  // edge, readies are compared with the arbitration model, and the model advances.
  task automatic tick();
    logic          gw, gr, rd_ok, ret_now;
    logic [95:0]   r96;
    cmd_t          c;
    rsp_t          r;
    ret_now = 1'b0;
    if (ret_q.size() > 0) begin
      if (ret_q[0] <= cyc) begin
        ret_now = (ret_q[0] == cyc);
        void'(ret_q.pop_front());
      end
    end
    usr_rd_dvld = man_dvld || ret_now;
    r96 = {$urandom, $urandom, $urandom};
    usr_rd_data = r96[UW-1:0];
    r96 = {$urandom, $urandom, $urandom};
    wr_req_data = r96[UW-1:0];
    wr_req_addr = AW'($urandom);
    rd_req_addr = AW'($urandom);

    @(negedge clk0);
    if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
      c = cmd_q.pop_front();
      chk("wr_strb", 128'(usr_wr_strb), 128'(c.is_wr));
      chk("rd_strb", 128'(usr_rd_strb), 128'(!c.is_wr));
      chk("usr_addr", 128'(usr_addr), 128'(c.addr));
      if (c.is_wr) chk("usr_wr_data", 128'(usr_wr_data), 128'(c.data));
      if (!c.is_wr && auto_ret) ret_q.push_back(cyc + 11);
      $display("cyc %0d cmd %s addr=%0h", cyc, c.is_wr ? "W" : "R", c.addr);
    end else if (usr_wr_strb || usr_rd_strb) begin
      chk("idle_strb", 128'({usr_wr_strb, usr_rd_strb}), 128'(0));
    end
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      r = rsp_q.pop_front();
      chk("rsp_valid", 128'(rd_rsp_valid), 128'(1));
      chk("rsp_tag", 128'(rd_rsp_tag), 128'(r.tag));
      chk("rsp_data", 128'(rd_rsp_data), 128'(r.data));
      seen_tags.push_back(rd_rsp_tag);
      $display("cyc %0d rsp tag=%0h", cyc, rd_rsp_tag);
    end else begin
      chk("rsp_idle", 128'(rd_rsp_valid), 128'(0));
    end
    chk("rd_inflight", 128'(rd_inflight), 128'(m_tags.size()));
    chk("rsp_underflow", 128'(rsp_underflow), 128'(m_uflow));

    rd_ok = rd_req_valid && (m_tags.size() < OUT);
    gr = m_run && rd_ok && (!wr_req_valid || m_streak == LIM);
    gw = m_run && wr_req_valid && !gr;
    chk("wr_ready", 128'(wr_req_ready), 128'(gw));
    chk("rd_ready", 128'(rd_req_ready), 128'(gr));
    if (gw) cmd_q.push_back('{cyc + 1, 1'b1, wr_req_addr, wr_req_data});
    if (gr) cmd_q.push_back('{cyc + 1, 1'b0, rd_req_addr, '0});
    if (usr_rd_dvld) begin
      if (m_tags.size() > 0) begin
        r.due = cyc + 1;
        r.data = usr_rd_data;
        r.tag = m_tags.pop_front();
        rsp_q.push_back(r);
      end else begin
        m_uflow = 1'b1;
      end
    end
    if (gr) m_tags.push_back(rd_req_tag);
    if (!rd_req_valid || gr) m_streak = 0;
    else if (gw && m_streak < LIM) m_streak++;
    m_run = phy_rdy;
    last_gr = gr;
    last_gw = gw;

    @(posedge clk0);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_ctl", 128'({usr_wr_strb, usr_rd_strb, rd_rsp_valid, rsp_underflow,
                         wr_req_ready, rd_req_ready}), 128'(0));
    chk("rst_inflight", 128'(rd_inflight), 128'(0));
    chk("rst_addr", 128'(usr_addr), 128'(0));
    chk("rst_wdata", 128'(usr_wr_data), 128'(0));
    chk("rst_rdata", 128'(rd_rsp_data), 128'(0));
    chk("rst_tag", 128'(rd_rsp_tag), 128'(0));
    m_run = 1'b0;
    m_streak = 0;
    m_uflow = 1'b0;
    cmd_q.delete();
    rsp_q.delete();
    m_tags.delete();
    @(posedge clk0);
    cyc++;
    #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    wr_req_valid = 1'b0;
    rd_req_valid = 1'b0;
    for (int i = 0; i < 60 && (m_tags.size() > 0 || rsp_q.size() > 0); i++) tick();
    chk("drain_inflight", 128'(rd_inflight), 128'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; phy_rdy = 1'b0; wr_req_valid = 1'b0; rd_req_valid = 1'b0;
    wr_req_addr = '0; wr_req_data = '0; rd_req_addr = '0; rd_req_tag = '0;
    usr_rd_data = '0; usr_rd_dvld = 1'b0; auto_ret = 1'b0; man_dvld = 1'b0;
    last_gr = 1'b0; last_gw = 1'b0; m_run = 1'b0; m_streak = 0; m_uflow = 1'b0;
    #2;
    do_reset();

    // Nothing granted before calibration; write wins the first RUN cycle.
    wr_req_valid = 1'b1;
    rd_req_valid = 1'b1;
    repeat (10) tick();
    phy_rdy = 1'b1;
    tick();
    chk("t1_first_wr", 128'({wr_req_ready, rd_req_ready}), 128'(2'b10));

    // Continuous contention: four writes then a read, repeating.
    auto_ret = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (last_gr) rd_req_tag = rd_req_tag + 1'b1;
    end
    drain();

    // Fill all slots with dvld withheld.
    auto_ret = 1'b0;
    rd_req_tag = '0;
    rd_req_valid = 1'b1;
    for (int i = 0; i < 40 && m_tags.size() < OUT; i++) begin
      tick();
      if (last_gr) rd_req_tag = rd_req_tag + 1'b1;
    end
    chk("t3_full_inflight", 128'(rd_inflight), 128'(16));
    repeat (3) tick();
    chk("t3_17th_blocked", 128'(rd_req_ready), 128'(0));
    man_dvld = 1'b1;
    tick();
    man_dvld = 1'b0;
    chk("t3_next_ready", 128'(rd_req_ready), 128'(1));
    chk("t3_rsp_tag", 128'({rd_rsp_valid, rd_rsp_tag}), 128'({1'b1, 4'h0}));
    tick();

    // Pop while full blocks the read; afterwards push and pop balance.
    chk("t5_full", 128'(rd_inflight), 128'(16));
    man_dvld = 1'b1;
    chk("t5_ready_full", 128'(rd_req_ready), 128'(0));
    tick();
    tick();
    tick();
    chk("t5_balanced", 128'(rd_inflight), 128'(15));
    rd_req_valid = 1'b0;
    for (int i = 0; i < 40 && m_tags.size() > 0; i++) tick();
    man_dvld = 1'b0;
    drain();

    // Fixed-latency returns come back in issue order.
    auto_ret = 1'b1;
    seen_tags.delete();
    rd_req_valid = 1'b1;
    rd_req_tag = 4'd3; tick();
    rd_req_tag = 4'd9; tick();
    rd_req_tag = 4'd5; tick();
    rd_req_valid = 1'b0;
    repeat (16) tick();
    chk("t4_rsp_count", 128'(seen_tags.size()), 128'(3));
    if (seen_tags.size() == 3) begin
      chk("t4_tag0", 128'(seen_tags[0]), 128'(3));
      chk("t4_tag1", 128'(seen_tags[1]), 128'(9));
      chk("t4_tag2", 128'(seen_tags[2]), 128'(5));
    end

    // Randomised traffic with occasional loss of calibration.
    for (int i = 0; i < 300; i++) begin
      wr_req_valid = 1'($urandom_range(0, 1));
      rd_req_valid = 1'($urandom_range(0, 1));
      rd_req_tag   = TW'($urandom);
      phy_rdy      = ($urandom_range(0, 15) != 0);
      tick();
    end
    phy_rdy = 1'b1;
    drain();

    // Response with nothing outstanding.
    man_dvld = 1'b1;
    tick();
    man_dvld = 1'b0;
    tick();
    chk("t6_underflow", 128'({rsp_underflow, rd_rsp_valid}), 128'(2'b10));

    // Reset in the middle of a burst; late returns count as underflow.
    do_reset();
    phy_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      wr_req_valid = 1'($urandom_range(0, 1));
      rd_req_valid = 1'b1;
      rd_req_tag   = TW'($urandom);
      tick();
    end
    do_reset();
    wr_req_valid = 1'b0;
    rd_req_valid = 1'b0;
    repeat (15) tick();
    chk("t6_late_uflow", 128'(rsp_underflow), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
